lc3_mem_arbiter: RTL and testbench
==================================

# lc3_mem_arbiter

Shares the single-port LC-3 main memory between two requesters: the CPU control/datapath (MAR/MDR path driven by the control FSM's CS/WE, waiting on READY) and a loader/debug port used to preload programs and inspect memory. It grants one requester at a time, sequences a fixed-latency memory access, and returns data with a one-cycle completion pulse. It sits between the CPU core and the memory macro.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 2, memory access cycles, legal range 1..15

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- cpu_cs  in  1  CPU request; held high until cpu_ready is seen
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU address (MAR)
- cpu_wdata  in  DATA_W  CPU write data (MDR)
- cpu_rdata  out  DATA_W  read data, valid when cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse to CPU
- ld_req  in  1  loader request; held high until ld_ack is seen
- ld_we  in  1  loader write / read
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_rdata  out  DATA_W  read data, valid when ld_ack=1
- ld_ack  out  1  one-cycle completion pulse to loader
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the last mem_en cycle
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any request is high, choose winner, latch its we/addr/wdata and id, load wait counter with MEM_LAT-1, go to ACCESS. No request: stay.
- ACCESS: mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values. Counter decrements each cycle; at 0 capture mem_rdata (reads only) into winner's rdata register, go to RESP.
- RESP: pulse winner's ready/ack for exactly one cycle; go to IDLE. Writes leave rdata registers unchanged.
- Requester inputs changing or dropping during ACCESS are ignored; the access completes and the pulse is still issued (no abort).
- Tie in IDLE (both requesting): round-robin by last_grant (see Configuration). A lone requester always wins.
- Counter width $clog2(MEM_LAT+1); no wrap: counter is only loaded in IDLE.

## Timing
- Request seen in IDLE cycle t -> mem_en cycles t+1..t+MEM_LAT -> ready/ack at t+MEM_LAT+1.
- Back-to-back: next grant earliest at t+MEM_LAT+2 (one IDLE cycle between accesses).
- Reset values: all outputs 0, state IDLE, counter 0, cpu_rdata=ld_rdata=0, last_grant=loader (CPU wins first tie).
- RESET mid-access: immediately IDLE, mem_en/mem_we drop asynchronously, no pulse issued, write may be partial.

## Configuration
- ARB_ROUND_ROBIN_EN defined: tie goes to the requester not in last_grant; last_grant updates on every grant.
- Not defined: fixed priority, CPU always wins ties; last_grant register removed.

## Structure
- Package lc3_mem_pkg: state enum (IDLE, ACCESS, RESP), requester id enum (REQ_CPU, REQ_LD), default MEM_LAT constant.
- Sub-module lc3_rr_arbiter2: two-input grant logic plus last_grant register, macro-controlled.

## Test plan
- Reset then cpu_cs=1, we=0, addr=x3000, mem holds x1234 (MEM_LAT=2) -> mem_en cycles 1-2, cpu_ready pulse cycle 3, cpu_rdata=x1234.
- Loader write addr=x3001 data=xABCD -> mem_we=1 for 2 cycles, ld_ack once; subsequent CPU read of x3001 returns xABCD.
- Both request same cycle after reset, hold -> CPU served first, loader next; with ARB_ROUND_ROBIN_EN, next tie goes to loader, without it CPU again.
- Change cpu_addr to x4000 during ACCESS of x3000 read -> mem_addr stays x3000, data from x3000.
- RESET pulsed in second ACCESS cycle -> mem_en=0 immediately, no cpu_ready, busy=0; request still high -> re-served normally after release.
- MEM_LAT=1 build: read completes with ready two cycles after request; MEM_LAT=15: exactly 15 mem_en cycles.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 main-memory arbiter.
// Used by lc3_rr_arbiter2 and lc3_mem_arbiter.
package lc3_mem_pkg;

  localparam int DEFAULT_MEM_LAT = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_e;

endpackage

// File: rtl/lc3_rr_arbiter2.sv
// Two-input grant logic for the LC-3 memory arbiter.
// With ARB_ROUND_ROBIN_EN defined, ties alternate via a last_grant register;
// otherwise the CPU always wins ties.
module lc3_rr_arbiter2
  import lc3_mem_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic    CLK,
  input  logic    RESET,
  input  logic    take,
`endif
  input  logic    cpu_req,
  input  logic    ld_req,
  output logic    any_req,
  output req_id_e grant_id
);

  assign any_req = cpu_req | ld_req;

`ifdef ARB_ROUND_ROBIN_EN
  req_id_e last_grant;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    grant_id = REQ_LD;
    if (cpu_req && (!ld_req || last_grant == REQ_LD))
      grant_id = REQ_CPU;
  end

  // Reset value REQ_LD makes the CPU win the first tie.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      last_grant <= REQ_LD;
    else if (take && any_req)
      last_grant <= grant_id;
  end
`else
  always_comb begin
    grant_id = REQ_LD;
    if (cpu_req)
      grant_id = REQ_CPU;
  end
`endif

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares the single-port LC-3 memory between the CPU and the loader/debug port.
// Optional round-robin tie-breaking via ARB_ROUND_ROBIN_EN (default: CPU priority).
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = DEFAULT_MEM_LAT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  req_id_e           owner;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic    any_req;
  req_id_e grant_id;
  logic    sel_cpu;

  lc3_rr_arbiter2 u_arb (
`ifdef ARB_ROUND_ROBIN_EN
    .CLK      (CLK),
    .RESET    (RESET),
    .take     (state == IDLE),
`endif
    .cpu_req  (cpu_cs),
    .ld_req   (ld_req),
    .any_req  (any_req),
    .grant_id (grant_id)
  );

  assign sel_cpu = (grant_id == REQ_CPU);

  // Requester inputs are sampled only in IDLE; later changes cannot disturb the access.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= REQ_CPU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cpu_rdata <= '0;
      ld_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ACCESS;
            cnt       <= CNT_LOAD;
            owner     <= grant_id;
            lat_we    <= sel_cpu ? cpu_we    : ld_we;
            lat_addr  <= sel_cpu ? cpu_addr  : ld_addr;
            lat_wdata <= sel_cpu ? cpu_wdata : ld_wdata;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state <= RESP;
            if (!lat_we) begin
              if (owner == REQ_CPU) cpu_rdata <= mem_rdata;
              else                  ld_rdata  <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded straight from the state register so reset drops mem_en/mem_we at once.
  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_ready = (state == RESP) && (owner == REQ_CPU);
  assign ld_ack    = (state == RESP) && (owner == REQ_LD);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: transaction-level model of grant order,
// latency and memory contents, plus MEM_LAT=1 and MEM_LAT=15 instances.
module tb_lc3_mem_arbiter;
  import lc3_mem_pkg::*;

  localparam int          LAT   = 2;
  localparam logic [15:0] ROM_K = 16'hA5C3;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        cpu_cs = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_ready;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [15:0] ld_addr = '0, ld_wdata = '0, ld_rdata;
  logic        ld_ack;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  // Latency-variant instances share address, each has its own request line.
  logic        l1_cs = 1'b0, l15_cs = 1'b0;
  logic [15:0] x_addr = '0;
  logic [15:0] l1_rdata, l1_ld_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic [15:0] l15_rdata, l15_ld_rdata, l15_mem_addr, l15_mem_wdata, l15_mem_rdata;
  logic        l1_ready, l1_ack, l1_mem_en, l1_mem_we, l1_busy;
  logic        l15_ready, l15_ack, l15_mem_en, l15_mem_we, l15_busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] dev_mem [0:65535];
  logic [15:0] ref_mem [logic [15:0]];
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0, bd_data = '0;
  logic [15:0] last_cpu_rd, last_ld_rd;
  txn_t        cq[$];
  txn_t        lq[$];

  always #5 CLK = ~CLK;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .CLK(CLK), .RESET(RESET),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_lat1 (
    .CLK(CLK), .RESET(RESET),
    .cpu_cs(l1_cs), .cpu_we(1'b0), .cpu_addr(x_addr), .cpu_wdata(16'h0000),
    .cpu_rdata(l1_rdata), .cpu_ready(l1_ready),
    .ld_req(1'b0), .ld_we(1'b0), .ld_addr(16'h0000), .ld_wdata(16'h0000),
    .ld_rdata(l1_ld_rdata), .ld_ack(l1_ack),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .busy(l1_busy)
  );

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(15)) u_lat15 (
    .CLK(CLK), .RESET(RESET),
    .cpu_cs(l15_cs), .cpu_we(1'b0), .cpu_addr(x_addr), .cpu_wdata(16'h0000),
    .cpu_rdata(l15_rdata), .cpu_ready(l15_ready),
    .ld_req(1'b0), .ld_we(1'b0), .ld_addr(16'h0000), .ld_wdata(16'h0000),
    .ld_rdata(l15_ld_rdata), .ld_ack(l15_ack),
    .mem_en(l15_mem_en), .mem_we(l15_mem_we), .mem_addr(l15_mem_addr), .mem_wdata(l15_mem_wdata),
    .mem_rdata(l15_mem_rdata), .busy(l15_busy)
  );

  assign l1_mem_rdata  = l1_mem_addr ^ ROM_K;
  assign l15_mem_rdata = l15_mem_addr ^ ROM_K;

  // Memory macro model: combinational read, write on the clock edge.
  always @(posedge CLK) begin
    if (bd_we)                dev_mem[bd_addr]  <= bd_data;
    else if (mem_en && mem_we) dev_mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = dev_mem[mem_addr];

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge CLK);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    l1_cs = 1'b0; l15_cs = 1'b0; x_addr = '0;
    last_cpu_rd = '0; last_ld_rd = '0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic present_cpu(input int i);
    if (i < cq.size()) begin
      cpu_cs = 1'b1; cpu_we = cq[i].we; cpu_addr = cq[i].addr; cpu_wdata = cq[i].wdata;
    end else begin
      cpu_cs = 1'b0;
    end
  endtask

  task automatic present_ld(input int i);
    if (i < lq.size()) begin
      ld_req = 1'b1; ld_we = lq[i].we; ld_addr = lq[i].addr; ld_wdata = lq[i].wdata;
    end else begin
      ld_req = 1'b0;
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = 16'h3000 + 16'($urandom_range(0, 15));
    t.wdata = 16'($urandom);
    return t;
  endfunction

  // Both queues are presented right after reset; each requester keeps presenting its
  // next transaction as soon as the previous completion pulse is seen.
  // mode: 0 = inputs held, 1 = in-flight requester scrambles inputs, 2 = CPU addr -> x4000.
  task automatic run_scenario(input int mode);
    req_id_e     order[$];
    req_id_e     last_served, got;
    txn_t        cur;
    int          a, b, ci, li, k, cyc, due, en_cnt, we_cnt, budget;
    logic [15:0] exp_d, act_d;
    a = 0; b = 0; last_served = REQ_LD;
    while (a < cq.size() || b < lq.size()) begin
      if (b >= lq.size()) begin order.push_back(REQ_CPU); a++; end
      else if (a >= cq.size()) begin order.push_back(REQ_LD); b++; end
      else begin
`ifdef ARB_ROUND_ROBIN_EN
        got = (last_served == REQ_CPU) ? REQ_LD : REQ_CPU;
`else
        got = REQ_CPU;
`endif
        order.push_back(got);
        if (got == REQ_CPU) a++; else b++;
      end
      last_served = order[order.size()-1];
    end
    budget = order.size() * (LAT + 2) + 20;
    do_reset();
    ci = 0; li = 0; k = 0; cyc = 0; due = LAT + 1; en_cnt = 0; we_cnt = 0;
    present_cpu(ci);
    present_ld(li);
    while (k < order.size()) begin
      @(negedge CLK);
      cyc++;
      if (cyc > budget) begin
        checks++; errors++;
        $display("FAIL timeout: completion %0d of %0d never arrived", k, order.size());
        break;
      end
      cur = (order[k] == REQ_CPU) ? cq[ci] : lq[li];
      if (mem_en) begin
        en_cnt++;
        if (mem_we) we_cnt++;
        checks++;
        if (mem_addr !== cur.addr || mem_we !== cur.we || (cur.we && mem_wdata !== cur.wdata)) begin
          errors++;
          $display("FAIL mem_bus: got addr %h we %b wdata %h, expected addr %h we %b wdata %h",
                   mem_addr, mem_we, mem_wdata, cur.addr, cur.we, cur.wdata);
        end
        if (mode == 1 && order[k] == REQ_CPU) begin
          cpu_cs = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
        end else if (mode == 1) begin
          ld_req = 1'($urandom); ld_we = 1'($urandom); ld_addr = 16'($urandom); ld_wdata = 16'($urandom);
        end else if (mode == 2 && order[k] == REQ_CPU) begin
          cpu_addr = 16'h4000; cpu_wdata = 16'h0BAD;
        end
      end
      if (cpu_ready || ld_ack) begin
        got = cpu_ready ? REQ_CPU : REQ_LD;
        checks++;
        if ((cpu_ready && ld_ack) || got !== order[k]) begin
          errors++;
          $display("FAIL grant_order: txn %0d got ready=%b ack=%b, expected requester %0d",
                   k, cpu_ready, ld_ack, order[k]);
        end
        checks++;
        if (cyc !== due) begin
          errors++;
          $display("FAIL pulse_time: txn %0d at cycle %0d, expected %0d", k, cyc, due);
        end
        checks++;
        if (en_cnt !== LAT || we_cnt !== (cur.we ? LAT : 0) || busy !== 1'b1) begin
          errors++;
          $display("FAIL access_len: txn %0d mem_en %0d mem_we %0d busy %b, expected %0d %0d 1",
                   k, en_cnt, we_cnt, busy, LAT, cur.we ? LAT : 0);
        end
        if (cur.we) begin
          ref_mem[cur.addr] = cur.wdata;
          exp_d = (order[k] == REQ_CPU) ? last_cpu_rd : last_ld_rd;
        end else begin
          exp_d = ref_mem[cur.addr];
          if (order[k] == REQ_CPU) last_cpu_rd = exp_d; else last_ld_rd = exp_d;
        end
        act_d = (order[k] == REQ_CPU) ? cpu_rdata : ld_rdata;
        checks++;
        if (act_d !== exp_d) begin
          errors++;
          $display("FAIL rdata: txn %0d (we=%b addr %h) got %h expected %h", k, cur.we, cur.addr, act_d, exp_d);
        end
        if (order[k] == REQ_CPU) begin ci++; present_cpu(ci); end
        else begin li++; present_ld(li); end
        k++;
        due = cyc + LAT + 2;
        en_cnt = 0; we_cnt = 0;
      end
    end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after: busy %b mem_en %b, expected 0 0", busy, mem_en);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    cpu_cs = 1'b1; cpu_addr = 16'h3000; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h3001;
    @(negedge CLK);
    checks++;
    if ({cpu_ready, ld_ack, mem_en, mem_we, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready/ack/en/we/busy = %b, expected 00000",
               {cpu_ready, ld_ack, mem_en, mem_we, busy});
    end
    checks++;
    if ({cpu_rdata, ld_rdata, mem_addr, mem_wdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: cpu_rdata %h ld_rdata %h mem_addr %h mem_wdata %h, expected 0",
               cpu_rdata, ld_rdata, mem_addr, mem_wdata);
    end
    cpu_cs = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
  endtask

  task automatic test_cpu_read();
    poke(16'h3000, 16'h1234);
    cq = '{'{we: 1'b0, addr: 16'h3000, wdata: 16'h0000}};
    lq = '{};
    run_scenario(0);
  endtask

  task automatic test_loader_write();
    lq = '{'{we: 1'b1, addr: 16'h3001, wdata: 16'hABCD}};
    cq = '{};
    run_scenario(0);
    cq = '{'{we: 1'b0, addr: 16'h3001, wdata: 16'h0000}};
    lq = '{};
    run_scenario(0);
  endtask

  task automatic test_tie();
    cq = '{'{we: 1'b0, addr: 16'h3004, wdata: 16'h0}, '{we: 1'b0, addr: 16'h3005, wdata: 16'h0}};
    lq = '{'{we: 1'b0, addr: 16'h3006, wdata: 16'h0}, '{we: 1'b0, addr: 16'h3007, wdata: 16'h0}};
    run_scenario(0);
  endtask

  task automatic test_addr_change();
    cq = '{'{we: 1'b0, addr: 16'h3000, wdata: 16'h0}};
    lq = '{};
    run_scenario(2);
  endtask

  task automatic test_reset_mid_access();
    bit seen;
    do_reset();
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3002;
    repeat (2) @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0 || cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: mem_en %b mem_we %b busy %b ready %b, expected 0000",
               mem_en, mem_we, busy, cpu_ready);
    end
    @(negedge CLK);
    checks++;
    if (cpu_ready !== 1'b0 || cpu_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_hold: ready %b rdata %h, expected 0 0000", cpu_ready, cpu_rdata);
    end
    RESET = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge CLK);
      if (cpu_ready) begin
        checks++;
        if (c !== LAT + 1 || cpu_rdata !== ref_mem[16'h3002]) begin
          errors++;
          $display("FAIL reserve: ready at cycle %0d rdata %h, expected cycle %0d rdata %h",
                   c, cpu_rdata, LAT + 1, ref_mem[16'h3002]);
        end
        seen = 1'b1;
        cpu_cs = 1'b0;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reserve_missing: got no cpu_ready, expected one after reset release");
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      cq = '{}; lq = '{};
      for (int i = 0; i < int'($urandom_range(3, 8)); i++) cq.push_back(rand_txn());
      for (int i = 0; i < int'($urandom_range(3, 8)); i++) lq.push_back(rand_txn());
      run_scenario(1);
    end
  endtask

  task automatic test_latency_variants();
    bit seen1, seen15;
    int en1, en15;
    do_reset();
    x_addr = 16'h3000 + 16'($urandom_range(0, 255));
    l1_cs = 1'b1; l15_cs = 1'b1;
    seen1 = 1'b0; seen15 = 1'b0; en1 = 0; en15 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (l1_mem_en) en1++;
      if (l15_mem_en) en15++;
      if (l1_ready) begin
        checks++;
        if (c !== 2 || en1 !== 1 || l1_rdata !== (x_addr ^ ROM_K)) begin
          errors++;
          $display("FAIL lat1: ready at %0d en %0d rdata %h, expected 2 1 %h", c, en1, l1_rdata, x_addr ^ ROM_K);
        end
        seen1 = 1'b1; l1_cs = 1'b0;
      end
      if (l15_ready) begin
        checks++;
        if (c !== 16 || en15 !== 15 || l15_rdata !== (x_addr ^ ROM_K)) begin
          errors++;
          $display("FAIL lat15: ready at %0d en %0d rdata %h, expected 16 15 %h", c, en15, l15_rdata, x_addr ^ ROM_K);
        end
        seen15 = 1'b1; l15_cs = 1'b0;
      end
    end
    checks++;
    if (!seen1 || !seen15) begin
      errors++;
      $display("FAIL lat_missing: seen1 %b seen15 %b, expected 1 1", seen1, seen15);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    for (int i = 0; i < 16; i++) poke(16'h3000 + 16'(i), 16'($urandom));
    poke(16'h4000, 16'hBEEF);
    test_cpu_read();
    test_loader_write();
    test_tie();
    test_addr_change();
    test_reset_mid_access();
    test_random();
    test_latency_variants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
